// File: rtl/ripple_cap_pkg.sv
// Shared types and default widths for the ripple counter capture block.
// Imported by the capture top and its bench.
package ripple_cap_pkg;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    IDLE  = 2'd1,
    PEND  = 2'd2
  } cap_state_e;

  localparam int CNT_W_DEF    = 4;
  localparam int STABLE_N_DEF = 2;
  localparam int ACC_W_DEF    = 16;
  localparam int DELTA_W_DEF  = 8;

endpackage

// File: rtl/ripple_count_capture_if.sv
// Valid/ready record channel from the capture block to the event logger.
// Master drives the record, slave returns ready.
interface ripple_count_capture_if #(
  parameter int ACC_W   = 16,
  parameter int DELTA_W = 8
) ();

  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_count;
  logic [DELTA_W-1:0] out_delta;

  modport master (
    output out_valid,
    output out_count,
    output out_delta,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_count,
    input  out_delta,
    output out_ready
  );

endinterface

// File: rtl/ripple_count_capture_bit_sync.sv
// Two-flop per-bit synchronizer with async active-high reset.
// Each bit is synchronized independently; callers must filter skew.
module bit_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/ripple_count_capture.sv
// Captures an async ripple count, filters transients, and emits
// wrap-aware delta records with a running accumulator.
module ripple_count_capture
  import ripple_cap_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int STABLE_N = STABLE_N_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int DELTA_W  = DELTA_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CNT_W-1:0]       cnt_in,
  input  logic                   clr,
  ripple_count_capture_if.master out_if,
  output logic                   overflow,
  output logic                   lost
);

  localparam int SW = $clog2(STABLE_N);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_N - 1);
  localparam logic [SW-1:0] STAB_ACC = SW'(STABLE_N - 2);

  logic [CNT_W-1:0]   s2;
  logic [CNT_W-1:0]   prev_q;
  logic [SW-1:0]      stab_q, stab_d;
  logic [CNT_W-1:0]   last_q, last_d;
  cap_state_e         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DELTA_W-1:0] delta_q, delta_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic               lost_q, lost_d;

  logic               accept;
  logic               has_d;
  logic               hs;
  logic [CNT_W-1:0]   d;
  logic [ACC_W:0]     acc_sum;
  logic [DELTA_W:0]   dsum;
  logic [DELTA_W-1:0] d_ext;

  bit_sync #(.W(CNT_W)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (cnt_in),
    .q_o   (s2)
  );

  always_comb begin
    stab_d = stab_q;
    if (s2 != prev_q) begin
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + 1'b1;
    end
  end

  // fires exactly once per settled value: the cycle it reaches STABLE_N samples
  assign accept  = (s2 == prev_q) && (stab_q == STAB_ACC);
  assign d       = s2 - last_q;
  assign has_d   = accept && (d != '0);
  assign hs      = valid_q && out_if.out_ready;
  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(d);
  assign dsum    = {1'b0, delta_q} + (DELTA_W+1)'(d);
  assign d_ext   = DELTA_W'(d);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    delta_d = delta_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    lost_d  = lost_q;
    last_d  = accept ? s2 : last_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      delta_d = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      lost_d  = 1'b0;
    end else begin
      unique case (state_q)
        PRIME: begin
          if (accept) state_d = IDLE;
        end
        IDLE: begin
          if (has_d) begin
            acc_d   = acc_sum[ACC_W-1:0];
            ovf_d   = ovf_q | acc_sum[ACC_W];
            delta_d = d_ext;
            valid_d = 1'b1;
            state_d = PEND;
          end
        end
        PEND: begin
          if (has_d) begin
            acc_d = acc_sum[ACC_W-1:0];
            ovf_d = ovf_q | acc_sum[ACC_W];
            if (hs) begin
              delta_d = d_ext;
            end else if (dsum[DELTA_W]) begin
              delta_d = '1;
              lost_d  = 1'b1;
            end else begin
              delta_d = dsum[DELTA_W-1:0];
            end
          end else if (hs) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = PRIME;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      stab_q  <= '0;
      last_q  <= '0;
      state_q <= PRIME;
      acc_q   <= '0;
      delta_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      prev_q  <= s2;
      stab_q  <= stab_d;
      last_q  <= last_d;
      state_q <= state_d;
      acc_q   <= acc_d;
      delta_q <= delta_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      lost_q  <= lost_d;
    end
  end

  // accumulator only moves together with a record, so it doubles as out_count
  assign out_if.out_valid = valid_q;
  assign out_if.out_count = acc_q;
  assign out_if.out_delta = delta_q;
  assign overflow         = ovf_q;
  assign lost             = lost_q;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Scoreboard bench for ripple_count_capture: directed ripple sequences,
// queued expected records, negedge monitor on the record channel.
module tb_ripple_count_capture;

  typedef struct {
    logic [15:0] cnt;
    logic [7:0]  dl;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic [3:0] cnt_in;
  logic       overflow;
  logic       lost;

  int   n_tests = 0;
  int   n_fail  = 0;
  rec_t exp_q[$];
  rec_t mon_r;

  ripple_count_capture_if #(.ACC_W(16), .DELTA_W(8)) bus ();

  ripple_count_capture dut (
    .clk      (clk),
    .reset    (reset),
    .cnt_in   (cnt_in),
    .clr      (clr),
    .out_if   (bus.master),
    .overflow (overflow),
    .lost     (lost)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(logic [3:0] v, int n);
    cnt_in = v;
    cyc(n);
  endtask

  task automatic expect_rec(int c, int dl);
    rec_t r;
    r.cnt = 16'(c);
    r.dl  = 8'(dl);
    exp_q.push_back(r);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_record: count %0d delta %0d, required none",
                 bus.out_count, bus.out_delta);
      end else begin
        mon_r = exp_q.pop_front();
        chk("rec_count", 32'(bus.out_count), 32'(mon_r.cnt));
        chk("rec_delta", 32'(bus.out_delta), 32'(mon_r.dl));
      end
    end
  end

  initial begin
    reset         = 1'b1;
    clr           = 1'b0;
    cnt_in        = 4'd0;
    bus.out_ready = 1'b1;
    cyc(2);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_count", 32'(bus.out_count), 0);
    chk("rst_delta", 32'(bus.out_delta), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_lost", 32'(lost), 0);

    reset = 1'b0;
    cyc(10);
    chk("t1_no_record", 32'(bus.out_valid), 0);

    expect_rec(3, 3);
    cnt_in = 4'd3;
    cyc(3);
    chk("t2_lat_early", 32'(bus.out_valid), 0);
    cyc(1);
    chk("t2_lat_edge", 32'(bus.out_valid), 1);
    cyc(4);

    expect_rec(14, 11); hold(4'd14, 5);
    expect_rec(15, 1);  hold(4'd15, 5);
    expect_rec(16, 1);  hold(4'd0, 5);
    expect_rec(17, 1);  hold(4'd1, 5);
    expect_rec(30, 13); hold(4'd14, 5);
    expect_rec(33, 3);  hold(4'd1, 5);

    expect_rec(39, 6);  hold(4'd7, 5);
    hold(4'd6, 1);
    hold(4'd4, 1);
    expect_rec(40, 1);  hold(4'd8, 6);

    bus.out_ready = 1'b0;
    hold(4'd13, 5);
    hold(4'd2, 5);
    hold(4'd7, 5);
    chk("t5_pend_valid", 32'(bus.out_valid), 1);
    chk("t5_merge_delta", 32'(bus.out_delta), 15);
    chk("t5_merge_count", 32'(bus.out_count), 55);
    for (int k = 1; k <= 16; k++) hold(4'(7 - k), 5);
    chk("t5_at_max_delta", 32'(bus.out_delta), 255);
    chk("t5_at_max_lost", 32'(lost), 0);
    chk("t5_at_max_count", 32'(bus.out_count), 295);
    hold(4'd6, 5);
    chk("t5_sat_delta", 32'(bus.out_delta), 255);
    chk("t5_sat_lost", 32'(lost), 1);
    chk("t5_sat_count", 32'(bus.out_count), 310);
    chk("t5_no_ovf", 32'(overflow), 0);
    expect_rec(310, 255);
    bus.out_ready = 1'b1;
    cyc(3);
    chk("t5_drained", 32'(bus.out_valid), 0);
    chk("t5_lost_sticky", 32'(lost), 1);

    bus.out_ready = 1'b0;
    hold(4'd9, 5);
    chk("t6_pend_count", 32'(bus.out_count), 313);
    chk("t6_pend_delta", 32'(bus.out_delta), 3);
    cnt_in = 4'd12;
    cyc(3);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("t6_clr_valid", 32'(bus.out_valid), 0);
    chk("t6_clr_count", 32'(bus.out_count), 0);
    chk("t6_clr_delta", 32'(bus.out_delta), 0);
    chk("t6_clr_lost", 32'(lost), 0);
    bus.out_ready = 1'b1;
    cyc(8);
    expect_rec(2, 2);
    hold(4'd14, 6);

    bus.out_ready = 1'b0;
    hold(4'd15, 5);
    chk("t6_rec2_count", 32'(bus.out_count), 3);
    chk("t6_rec2_valid", 32'(bus.out_valid), 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("t6_arst_valid", 32'(bus.out_valid), 0);
    chk("t6_arst_count", 32'(bus.out_count), 0);
    chk("t6_arst_delta", 32'(bus.out_delta), 0);
    cnt_in = 4'd0;
    cyc(2);
    reset = 1'b0;
    cyc(6);
    expect_rec(5, 5);
    bus.out_ready = 1'b1;
    hold(4'd5, 6);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
